// File: rtl/spike_decoder_pl.sv
// spike_decoder_pl: captures an N_NUM-bit spike vector on entry to the SYN_ACCU
// controller state and streams it LANES spikes per beat over valid/ready, with the
// register-file address of each group. Optional zero-skip drops empty groups and
// ends the pass once no spikes remain. accu_fin pulses for one cycle at pass end.
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-low reset
//   state            controller state
//   spike_stream_in  spike vector, bit i = neuron i (sampled at load)
//   skip_en          zero-skip request (sampled at load)
//   out_ready        downstream accepts the current beat
//   out_valid        spike/rf_addr hold a valid beat
//   spike            spike bits of the current group, bit 0 = lowest neuron
//   rf_addr          neuron index of spike[0]
//   accu_fin         one-cycle pulse at end of pass
//   busy             high in SHIFT and FIN
module spike_decoder_pl #(
    parameter int unsigned          N_NUM         = 32,
    parameter int unsigned          LANES         = 2,
    parameter int unsigned          STATE_W       = 3,
    parameter logic [STATE_W-1:0]   SYN_ACCU_CODE = 3'b010
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [STATE_W-1:0]         state,
    input  logic [N_NUM-1:0]           spike_stream_in,
    input  logic                       skip_en,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [LANES-1:0]           spike,
    output logic [$clog2(N_NUM)-1:0]   rf_addr,
    output logic                       accu_fin,
    output logic                       busy
);

    localparam int unsigned GROUPS = N_NUM / LANES;
    localparam int unsigned AW     = $clog2(N_NUM);
    localparam int unsigned GW     = $clog2(GROUPS + 1);

    // Elaboration-time parameter sanity
    if ((N_NUM % LANES) != 0) begin : g_bad_nnum
        $error("spike_decoder_pl: N_NUM must be a multiple of LANES");
    end
    if ((LANES == 0) || (LANES > N_NUM) || ((LANES & (LANES - 1)) != 0)) begin : g_bad_lanes
        $error("spike_decoder_pl: LANES must be a power of two in 1..N_NUM");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [N_NUM-1:0]   shift_reg, shift_d;
    logic [AW-1:0]      addr_d;
    logic [GW-1:0]      grp_cnt, grp_d;
    logic               skip_q, skip_d;
    logic [STATE_W-1:0] state_q;
    logic               out_valid_d;
    logic [LANES-1:0]   spike_d;
    logic               accu_fin_d;
    logic               busy_d;

    logic               in_accu_c;
    logic               entry_c;
    logic               last_grp_c;
    logic [N_NUM-1:0]   shifted_c;

    assign in_accu_c  = (state == SYN_ACCU_CODE);
    assign entry_c    = in_accu_c && (state_q != SYN_ACCU_CODE);
    assign last_grp_c = (grp_cnt == GW'(GROUPS - 1));
    assign shifted_c  = shift_reg >> LANES;

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q     <= IDLE;
            shift_reg <= '0;
            rf_addr   <= '0;
            grp_cnt   <= '0;
            skip_q    <= 1'b0;
            state_q   <= '0;
            out_valid <= 1'b0;
            spike     <= '0;
            accu_fin  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            shift_reg <= shift_d;
            rf_addr   <= addr_d;
            grp_cnt   <= grp_d;
            skip_q    <= skip_d;
            state_q   <= state;
            out_valid <= out_valid_d;
            spike     <= spike_d;
            accu_fin  <= accu_fin_d;
            busy      <= busy_d;
        end
    end

    // Next-state and next-output logic; outputs are registered from the next values
    always_comb begin
        fsm_d   = fsm_q;
        shift_d = shift_reg;
        addr_d  = rf_addr;
        grp_d   = grp_cnt;
        skip_d  = skip_q;

        unique case (fsm_q)
            IDLE: begin
                if (entry_c) begin
                    shift_d = spike_stream_in;
                    addr_d  = '0;
                    grp_d   = '0;
                    skip_d  = skip_en;
                    fsm_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (!in_accu_c) begin
                    fsm_d = IDLE;
                end else if (skip_q && (shift_reg == '0)) begin
                    fsm_d = FIN;
                end else if (skip_q && (shift_reg[LANES-1:0] == '0)) begin
                    shift_d = shifted_c;
                    addr_d  = rf_addr + AW'(LANES);
                    grp_d   = grp_cnt + GW'(1);
                    if (last_grp_c) fsm_d = FIN;
                end else if (out_valid && out_ready) begin
                    shift_d = shifted_c;
                    addr_d  = rf_addr + AW'(LANES);
                    grp_d   = grp_cnt + GW'(1);
                    // With zero-skip, finish as soon as the last spike has been sent
                    if (last_grp_c || (skip_q && (shifted_c == '0))) fsm_d = FIN;
                end
            end
            FIN: begin
                fsm_d = in_accu_c ? DONE : IDLE;
            end
            DONE: begin
                if (!in_accu_c) fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase

        // Datapath returns to zero whenever the block goes idle
        if (fsm_d == IDLE) begin
            shift_d = '0;
            addr_d  = '0;
            grp_d   = '0;
        end

        // A beat is offered unless zero-skip will drop the pending group
        out_valid_d = (fsm_d == SHIFT) && (!skip_d || (shift_d[LANES-1:0] != '0));
        spike_d     = out_valid_d ? shift_d[LANES-1:0] : '0;
        accu_fin_d  = (fsm_d == FIN);
        busy_d      = (fsm_d == SHIFT) || (fsm_d == FIN);
    end

endmodule

// File: tb/tb_spike_decoder_pl.sv
// Directed testbench for spike_decoder_pl: default (32/2) and swept (64/4) instances.
module tb_spike_decoder_pl;

    localparam logic [2:0] SYN = 3'b010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  state = 3'b000;
    logic [31:0] vec1 = '0;
    logic [63:0] vec2 = '0;
    logic        skip_en = 1'b0;
    logic        out_ready = 1'b1;

    logic        ov1, fin1, busy1;
    logic [1:0]  spk1;
    logic [4:0]  addr1;
    logic        ov2, fin2, busy2;
    logic [3:0]  spk2;
    logic [5:0]  addr2;

    spike_decoder_pl u_dut (
        .clk(clk), .rst(rst), .state(state), .spike_stream_in(vec1),
        .skip_en(skip_en), .out_ready(out_ready), .out_valid(ov1),
        .spike(spk1), .rf_addr(addr1), .accu_fin(fin1), .busy(busy1)
    );

    spike_decoder_pl #(.N_NUM(64), .LANES(4)) u_dut4 (
        .clk(clk), .rst(rst), .state(state), .spike_stream_in(vec2),
        .skip_en(skip_en), .out_ready(out_ready), .out_valid(ov2),
        .spike(spk2), .rf_addr(addr2), .accu_fin(fin2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int nbeats, fin_cyc, fin_count;
    int b_spk[64];
    int b_addr[64];
    int b_cyc[64];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pass starting at cycle T (now); cycle offsets are relative to T
    task automatic run_pass(input logic sel, input logic [63:0] vec, input logic skip,
                            input int stall_lo, input int stall_hi, input int abort_cyc,
                            input int max_cyc, input int stall_addr, input int stall_spk);
        logic       v, f;
        logic [3:0] s;
        logic [5:0] a;
        nbeats = 0; fin_cyc = -1; fin_count = 0;
        vec1 = vec[31:0]; vec2 = vec; skip_en = skip; state = SYN; out_ready = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            tick();
            if (c == 1) begin
                vec1 = ~vec[31:0]; vec2 = ~vec; skip_en = ~skip;
            end
            out_ready = !(c >= stall_lo && c <= stall_hi);
            if (c == abort_cyc) state = 3'b000;
            v = sel ? ov2   : ov1;
            s = sel ? spk2  : {2'b00, spk1};
            a = sel ? addr2 : {1'b0, addr1};
            f = sel ? fin2  : fin1;
            if (v && !out_ready) begin
                check("stall_addr", 64'(a), 64'(stall_addr));
                check("stall_spike", 64'(s), 64'(stall_spk));
            end
            if (v && out_ready && state == SYN && nbeats < 64) begin
                b_spk[nbeats] = int'(s); b_addr[nbeats] = int'(a); b_cyc[nbeats] = c;
                nbeats++;
            end
            if (f) begin
                fin_count++;
                if (fin_cyc < 0) fin_cyc = c;
            end
        end
        state = 3'b000; out_ready = 1'b1; skip_en = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int cnt;
        // Reset values
        tick(); tick();
        check("rst_valid", 64'(ov1), 64'(0));
        check("rst_spike", 64'(spk1), 64'(0));
        check("rst_addr",  64'(addr1), 64'(0));
        check("rst_fin",   64'(fin1), 64'(0));
        check("rst_busy",  64'(busy1), 64'(0));
        rst = 1'b1;
        tick();

        // Async reset mid-pass, then reload on the first edge after release
        vec1 = 32'hFFFF_FFFF; state = SYN; out_ready = 1'b0;
        tick(); tick();
        check("mp_valid", 64'(ov1), 64'(1));
        #2 rst = 1'b0;
        #1;
        check("mp_rst_valid", 64'(ov1), 64'(0));
        check("mp_rst_spike", 64'(spk1), 64'(0));
        check("mp_rst_busy",  64'(busy1), 64'(0));
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        check("reload_valid", 64'(ov1), 64'(1));
        check("reload_addr",  64'(addr1), 64'(0));
        check("reload_spike", 64'(spk1), 64'(3));
        state = 3'b000; out_ready = 1'b1;
        tick(); tick();
        check("reload_abort_busy", 64'(busy1), 64'(0));

        // Full pass, skip off
        run_pass(1'b0, 64'h8000_0003, 1'b0, 0, -1, 0, 22, 0, 0);
        check("a_beats", 64'(nbeats), 64'(16));
        check("a_b0_spk", 64'(b_spk[0]), 64'(3));
        check("a_b0_cyc", 64'(b_cyc[0]), 64'(1));
        check("a_b15_spk", 64'(b_spk[15]), 64'(2));
        check("a_b15_addr", 64'(b_addr[15]), 64'(30));
        cnt = 0;
        for (int k = 1; k < 15; k++) if (b_spk[k] != 0) cnt++;
        check("a_mid_zero", 64'(cnt), 64'(0));
        check("a_fin_cyc", 64'(fin_cyc), 64'(17));
        check("a_fin_cnt", 64'(fin_count), 64'(1));

        // Backpressure on beat 4
        run_pass(1'b0, 64'h8000_0303, 1'b0, 5, 7, 0, 24, 8, 3);
        check("b_beats", 64'(nbeats), 64'(16));
        check("b_b4_spk", 64'(b_spk[4]), 64'(3));
        check("b_b4_addr", 64'(b_addr[4]), 64'(8));
        check("b_b4_cyc", 64'(b_cyc[4]), 64'(8));
        check("b_fin_cyc", 64'(fin_cyc), 64'(20));

        // Zero-skip, single spike at neuron 16
        run_pass(1'b0, 64'h0001_0000, 1'b1, 0, -1, 0, 14, 0, 0);
        check("c_beats", 64'(nbeats), 64'(1));
        check("c_spk", 64'(b_spk[0]), 64'(1));
        check("c_addr", 64'(b_addr[0]), 64'(16));
        check("c_cyc", 64'(b_cyc[0]), 64'(9));
        check("c_fin_cyc", 64'(fin_cyc), 64'(10));

        // Zero-skip, all-zero vector
        run_pass(1'b0, 64'h0, 1'b1, 0, -1, 0, 6, 0, 0);
        check("d_beats", 64'(nbeats), 64'(0));
        check("d_fin_cyc", 64'(fin_cyc), 64'(2));

        // Skip off, all-zero vector
        run_pass(1'b0, 64'h0, 1'b0, 0, -1, 0, 20, 0, 0);
        check("e_beats", 64'(nbeats), 64'(16));
        check("e_b15_addr", 64'(b_addr[15]), 64'(30));
        check("e_fin_cyc", 64'(fin_cyc), 64'(17));

        // Abort after beat 5
        run_pass(1'b0, 64'h0000_0FFF, 1'b0, 0, -1, 7, 10, 0, 0);
        check("f_beats", 64'(nbeats), 64'(6));
        check("f_b5_addr", 64'(b_addr[5]), 64'(10));
        check("f_fin_cnt", 64'(fin_count), 64'(0));
        check("f_idle_valid", 64'(ov1), 64'(0));
        check("f_idle_busy", 64'(busy1), 64'(0));
        check("f_idle_addr", 64'(addr1), 64'(0));

        // Re-entry with a new vector
        run_pass(1'b0, 64'h0000_000C, 1'b0, 0, -1, 0, 20, 0, 0);
        check("g_b0_addr", 64'(b_addr[0]), 64'(0));
        check("g_b0_spk", 64'(b_spk[0]), 64'(0));
        check("g_b1_spk", 64'(b_spk[1]), 64'(3));
        check("g_b1_addr", 64'(b_addr[1]), 64'(2));
        check("g_fin_cyc", 64'(fin_cyc), 64'(17));

        // LANES=4, N_NUM=64 instance
        run_pass(1'b1, 64'hF000_0000_0000_0001, 1'b0, 0, -1, 0, 20, 0, 0);
        check("s_beats", 64'(nbeats), 64'(16));
        check("s_b0_spk", 64'(b_spk[0]), 64'(1));
        check("s_b15_spk", 64'(b_spk[15]), 64'(15));
        check("s_b15_addr", 64'(b_addr[15]), 64'(60));
        cnt = 0;
        for (int k = 0; k < 16; k++) if (b_addr[k] != 4 * k) cnt++;
        check("s_addr_steps", 64'(cnt), 64'(0));
        check("s_fin_cyc", 64'(fin_cyc), 64'(17));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
